ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. Sends one command byte (e.g. 8'hED set-LEDs, 8'hFF reset) from the FPGA to the keyboard over the open-drain clock/data pair, using the standard inhibit / request-to-send / device-clocked shift / ack sequence. It sits beside the PS/2 receive path, in front of the keyboard command logic, and shares the same pads through open-drain enables.

---
 rtl/ps2_pkg.sv | 40 ++++
 rtl/ps2_host_tx_if.sv | 39 +++
 rtl/ps2_sync_edge.sv | 44 ++++
 rtl/ps2_host_tx.sv | 233 +++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared PS/2 definitions for the host transmit path and its neighbours:
//   - ps2_tx_state_t : host-to-device transmitter state encoding
//   - CMD_*          : keyboard command bytes sent by the host
//   - RSP_*          : device response bytes
//   - BREAK/SPACE/ENTER : scan codes used by the receive/decode side
//   - odd_parity()   : parity bit for a PS/2 frame (odd parity over 8 bits)
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_tx_state_t;

  // Host commands
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // Device responses
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;

  // Scan codes
  localparam logic [7:0] BREAK        = 8'hF0;
  localparam logic [7:0] SPACE        = 8'h29;
  localparam logic [7:0] ENTER        = 8'h5A;

  // The parity bit makes the total count of ones over data+parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ---------------------------------------------------------------------------
// ps2_host_tx_if
// Command-side handshake between the keyboard command logic (master) and the
// PS/2 host transmitter (slave).
//   tx_data  : command byte, taken when tx_valid && tx_ready
//   tx_valid : request to send tx_data
//   tx_ready : transmitter idle and able to accept a byte
//   busy     : transmitter is working on a frame
//   done     : one-cycle pulse, frame acked by the device and lines idle
//   error    : one-cycle pulse, timeout or negative ack
// ---------------------------------------------------------------------------
interface ps2_host_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  busy,
    input  done,
    input  error
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output busy,
    output done,
    output error
  );

endinterface

// File: rtl/ps2_sync_edge.sv
// ---------------------------------------------------------------------------
// ps2_sync_edge
// Two-flop synchroniser for an asynchronous PS/2 pad input plus a one-cycle
// falling-edge strobe on the synchronised level.
//   clk     : system clock
//   rst_n   : synchronous active-low reset
//   i_async : raw pad input
//   o_level : synchronised level (2 cycles of latency)
//   o_fall  : high for one cycle when o_level goes 1 -> 0
// All flops reset to RESET_VAL so an idle (pulled-up) line produces no
// spurious edge when reset is released.
// ---------------------------------------------------------------------------
module ps2_sync_edge #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_prev <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  // Combinational from the synchronised pair so the consumer can register
  // its response on the very next edge.
  assign o_fall  = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard
// using inhibit (clock held low), request-to-send (data low = start bit),
// device-clocked shifting of 8 data bits + odd parity + stop, then samples
// the device ack bit and waits for both lines to return high.
//
// Ports:
//   clk         : system clock, rising edge
//   rst_n       : synchronous active-low reset
//   tx          : command handshake (tx_data/tx_valid in; tx_ready/busy/
//                 done/error out)
//   ps2_clk_i   : PS/2 clock pad input (asynchronous)
//   ps2_data_i  : PS/2 data pad input (asynchronous)
//   ps2_clk_oe  : 1 pulls the clock pad low, 0 releases it
//   ps2_data_oe : 1 pulls the data pad low, 0 releases it
// ---------------------------------------------------------------------------
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15_000
) (
  input  logic          clk,
  input  logic          rst_n,
  ps2_host_tx_if.slave  tx,
  input  logic          ps2_clk_i,
  input  logic          ps2_data_i,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe
);

  localparam int INHIBIT_CYC = (CLK_HZ / 1_000_000) * INHIBIT_US;
  localparam int TIMEOUT_CYC = (CLK_HZ / 1_000_000) * TIMEOUT_US;
  localparam int INH_W       = $clog2(INHIBIT_CYC + 1);
  localparam int WDOG_W      = $clog2(TIMEOUT_CYC + 1);

  localparam logic [INH_W-1:0]  INH_LAST  = INH_W'(INHIBIT_CYC - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);

  // -------------------------------------------------------------------------
  // Pad conditioning
  // -------------------------------------------------------------------------
  logic w_clk_level;
  logic w_clk_fall;
  logic w_data_level;
  logic w_data_fall_unused;

  ps2_sync_edge #(.RESET_VAL(1'b1)) u_clk_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (ps2_clk_i),
    .o_level (w_clk_level),
    .o_fall  (w_clk_fall)
  );

  ps2_sync_edge #(.RESET_VAL(1'b1)) u_data_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (ps2_data_i),
    .o_level (w_data_level),
    .o_fall  (w_data_fall_unused)
  );

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  ps2_tx_state_t     r_state;
  logic [8:0]        r_shift;      // {parity, data[7:0]}, shifted out LSB first
  logic [3:0]        r_bit_cnt;    // falls seen in SEND
  logic [INH_W-1:0]  r_inh_cnt;
  logic [WDOG_W-1:0] r_wdog_cnt;
  logic              r_clk_oe;
  logic              r_data_oe;
  logic              r_done;
  logic              r_error;

  ps2_tx_state_t     w_state_next;
  logic [8:0]        w_shift_next;
  logic [3:0]        w_bit_cnt_next;
  logic [INH_W-1:0]  w_inh_cnt_next;
  logic [WDOG_W-1:0] w_wdog_cnt_next;
  logic              w_clk_oe_next;
  logic              w_data_oe_next;
  logic              w_done_next;
  logic              w_error_next;
  logic              w_wdog_active;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_inh_cnt  <= '0;
      r_wdog_cnt <= '0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_inh_cnt  <= w_inh_cnt_next;
      r_wdog_cnt <= w_wdog_cnt_next;
      r_clk_oe   <= w_clk_oe_next;
      r_data_oe  <= w_data_oe_next;
      r_done     <= w_done_next;
      r_error    <= w_error_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state / output logic. The pad enables are registered, and their
  // next values are chosen together with the state transition so the pads
  // always reflect the state currently held in r_state.
  // -------------------------------------------------------------------------
  assign w_wdog_active = (r_state == SEND) || (r_state == ACK) || (r_state == WAIT_IDLE);

  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_bit_cnt_next  = r_bit_cnt;
    w_inh_cnt_next  = r_inh_cnt;
    w_wdog_cnt_next = r_wdog_cnt;
    w_clk_oe_next   = r_clk_oe;
    w_data_oe_next  = r_data_oe;
    w_done_next     = 1'b0;
    w_error_next    = 1'b0;

    case (r_state)
      IDLE: begin
        w_clk_oe_next  = 1'b0;
        w_data_oe_next = 1'b0;
        if (tx.tx_valid) begin
          w_shift_next    = {odd_parity(tx.tx_data), tx.tx_data};
          w_bit_cnt_next  = '0;
          w_inh_cnt_next  = '0;
          w_wdog_cnt_next = '0;
          w_clk_oe_next   = 1'b1;
          w_state_next    = INHIBIT;
        end
      end

      INHIBIT: begin
        if (r_inh_cnt == INH_LAST) begin
          // Start bit: pull data low while the clock is still held.
          w_data_oe_next = 1'b1;
          w_state_next   = RTS;
        end else begin
          w_inh_cnt_next = r_inh_cnt + 1'b1;
        end
      end

      RTS: begin
        // Release the clock; data stays low until the device's first fall.
        w_clk_oe_next  = 1'b0;
        w_data_oe_next = 1'b1;
        w_state_next   = SEND;
      end

      SEND: begin
        if (w_clk_fall) begin
          w_bit_cnt_next = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd9) begin
            // Tenth fall: stop bit is a released (high) line.
            w_data_oe_next = 1'b0;
            w_state_next   = ACK;
          end else begin
            // Open-drain: a 1 bit releases the line, a 0 bit pulls it low.
            w_data_oe_next = ~r_shift[0];
            w_shift_next   = {1'b0, r_shift[8:1]};
          end
        end
      end

      ACK: begin
        if (w_clk_fall) begin
          if (w_data_level) begin
            w_error_next   = 1'b1;
            w_clk_oe_next  = 1'b0;
            w_data_oe_next = 1'b0;
            w_state_next   = IDLE;
          end else begin
            w_state_next = WAIT_IDLE;
          end
        end
      end

      WAIT_IDLE: begin
        if (w_clk_level && w_data_level) begin
          w_done_next  = 1'b1;
          w_state_next = IDLE;
        end
      end

      default: begin
        w_clk_oe_next  = 1'b0;
        w_data_oe_next = 1'b0;
        w_state_next   = IDLE;
      end
    endcase

    // Watchdog for device clock activity. Every fall reloads it; expiry
    // aborts the frame and takes priority over a same-cycle done.
    if (w_wdog_active) begin
      if (w_clk_fall) begin
        w_wdog_cnt_next = '0;
      end else if (r_wdog_cnt == WDOG_LAST) begin
        w_wdog_cnt_next = '0;
        w_done_next     = 1'b0;
        w_error_next    = 1'b1;
        w_clk_oe_next   = 1'b0;
        w_data_oe_next  = 1'b0;
        w_state_next    = IDLE;
      end else begin
        w_wdog_cnt_next = r_wdog_cnt + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign tx.tx_ready = (r_state == IDLE);
  assign tx.busy     = (r_state != IDLE);
  assign tx.done     = r_done;
  assign tx.error    = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Drives ps2_host_tx against a simple open-drain PS/2 device model clocking
// at 1/100 of the system clock (10 kHz at CLK_HZ = 1 MHz).
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int CLK_HZ     = 1_000_000;
  localparam int INHIBIT_US = 100;
  localparam int TIMEOUT_US = 2000;

  logic clk;
  logic rst_n;
  logic ps2_clk_oe;
  logic ps2_data_oe;
  logic dev_clk_low;
  logic dev_data_low;
  logic clk_line;
  logic data_line;

  ps2_host_tx_if tx_if ();

  // Wired-AND open-drain bus with pull-ups.
  assign clk_line  = ~(ps2_clk_oe  | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_HZ     (CLK_HZ),
    .INHIBIT_US (INHIBIT_US),
    .TIMEOUT_US (TIMEOUT_US)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx          (tx_if),
    .ps2_clk_i   (clk_line),
    .ps2_data_i  (data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse monitor, sampled 2 ns after the rising edge.
  int   done_cnt   = 0;
  int   error_cnt  = 0;
  int   pulse_viol = 0;
  logic prev_done  = 1'b0;
  logic prev_error = 1'b0;

  always @(posedge clk) begin
    #2;
    if (tx_if.done)  done_cnt++;
    if (tx_if.error) error_cnt++;
    if ((tx_if.done && prev_done) || (tx_if.error && prev_error) ||
        (tx_if.done && tx_if.error))
      pulse_viol++;
    prev_done  = tx_if.done;
    prev_error = tx_if.error;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Handshake, inhibit length, RTS cycle and clock release. Returns at the
  // first negedge in SEND.
  task automatic start_frame(input logic [7:0] d);
    int t;
    int inh;
    check("ready_before_send", 32'(tx_if.tx_ready), 32'd1);
    tx_if.tx_data  = d;
    tx_if.tx_valid = 1'b1;
    t = 0;
    while (!ps2_clk_oe && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("accept_latency", 32'(t), 32'd1);
    tx_if.tx_valid = 1'b0;
    check("busy_after_accept", {30'd0, tx_if.busy, tx_if.tx_ready}, 32'b10);
    inh = 0;
    while (ps2_clk_oe && !ps2_data_oe && inh < 1000) begin
      inh++;
      @(negedge clk);
    end
    check("inhibit_cycles", 32'(inh), 32'd100);
    check("rts_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'b11);
    @(negedge clk);
    check("send_start_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'b01);
  endtask

  // Full frame with the device model. Optionally re-asserts tx_valid with
  // next_d after fall reassert_fall (0 = never).
  task automatic run_frame(input logic [7:0] d, input logic ack_bit,
                           input int reassert_fall, input logic [7:0] next_d,
                           output logic [9:0] bits);
    int lat;
    int d0;
    int e0;
    bits = '0;
    d0 = done_cnt;
    e0 = error_cnt;
    start_frame(d);
    lat = 0;
    for (int n = 1; n <= 11; n++) begin
      repeat (25) @(negedge clk);
      if (n == 11 && !ack_bit) dev_data_low = 1'b1;
      repeat (25) @(negedge clk);
      dev_clk_low = 1'b1;
      if (n == 11) begin
        for (int i = 1; i <= 50; i++) begin
          @(negedge clk);
          if (tx_if.error && lat == 0) lat = i;
        end
      end else begin
        repeat (50) @(negedge clk);
        bits[n-1] = data_line;
      end
      if (n == reassert_fall) begin
        tx_if.tx_data  = next_d;
        tx_if.tx_valid = 1'b1;
      end
      dev_clk_low = 1'b0;
    end
    if (ack_bit) begin
      check("nack_error_latency", 32'(lat), 32'd3);
    end else begin
      check("ack_no_error", 32'(lat), 32'd0);
      repeat (10) @(negedge clk);
      dev_data_low = 1'b0;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        if (tx_if.done) begin
          lat = i;
          break;
        end
      end
      check("done_latency", 32'(lat), 32'd3);
    end
    check("frame_done_pulses",  32'(done_cnt - d0),  32'(!ack_bit));
    check("frame_error_pulses", 32'(error_cnt - e0), 32'(ack_bit));
    check("end_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'b00);
    check("end_ready", 32'(tx_if.tx_ready), 32'd1);
    $display("frame data=%02h ack_bit=%0d sampled=%03h done=%0d error=%0d",
             d, ack_bit, bits, done_cnt - d0, error_cnt - e0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       ack_bit;
    logic [9:0] exp_bits;   // {stop, parity, data[7:0]} as seen on the wire
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [9:0] bits;
    int d0;
    int e0;
    int w;

    vecs[0] = '{data: 8'hED, ack_bit: 1'b0, exp_bits: 10'h3ED};
    vecs[1] = '{data: 8'h00, ack_bit: 1'b0, exp_bits: 10'h300};
    vecs[2] = '{data: 8'h03, ack_bit: 1'b0, exp_bits: 10'h303};
    vecs[3] = '{data: 8'h01, ack_bit: 1'b0, exp_bits: 10'h201};
    vecs[4] = '{data: 8'hED, ack_bit: 1'b1, exp_bits: 10'h3ED};

    rst_n          = 1'b0;
    tx_if.tx_data  = 8'h00;
    tx_if.tx_valid = 1'b0;
    dev_clk_low    = 1'b0;
    dev_data_low   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {26'd0, tx_if.tx_ready, tx_if.busy, tx_if.done, tx_if.error, ps2_clk_oe, ps2_data_oe},
          32'b100000);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_idle", {30'd0, tx_if.tx_ready, tx_if.busy}, 32'b10);

    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].data, vecs[v].ack_bit, 0, 8'h00, bits);
      check($sformatf("frame_bits_%0d", v), 32'(bits), 32'(vecs[v].exp_bits));
      repeat (20) @(negedge clk);
    end

    // tx_valid re-asserted during a frame is ignored; the queued byte then
    // goes out back-to-back after done.
    run_frame(8'hED, 1'b0, 3, 8'hEE, bits);
    check("busy_ignore_bits", 32'(bits), 32'h3ED);
    run_frame(8'hEE, 1'b0, 0, 8'h00, bits);
    check("back_to_back_bits", 32'(bits), 32'h3EE);
    repeat (20) @(negedge clk);

    // Reset after fall 5 of 8'hFF
    d0 = done_cnt;
    e0 = error_cnt;
    start_frame(8'hFF);
    for (int n = 1; n <= 5; n++) begin
      repeat (50) @(negedge clk);
      dev_clk_low = 1'b1;
      if (n < 5) begin
        repeat (50) @(negedge clk);
        dev_clk_low = 1'b0;
      end
    end
    repeat (10) @(negedge clk);
    check("busy_before_reset", 32'(tx_if.busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_mid_frame", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'b00);
    check("reset_mid_frame_busy", 32'(tx_if.busy), 32'd0);
    rst_n = 1'b1;
    dev_clk_low = 1'b0;
    repeat (200) @(negedge clk);
    check("reset_no_pulses", 32'((done_cnt - d0) + (error_cnt - e0)), 32'd0);
    $display("frame data=ff reset after fall 5 busy=%0d", tx_if.busy);

    // Reset while the host is inhibiting the clock
    tx_if.tx_data  = 8'hF0;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("inhibit_clk_oe", 32'(ps2_clk_oe), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_in_inhibit", {29'd0, ps2_clk_oe, ps2_data_oe, tx_if.busy}, 32'b000);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    $display("frame data=f0 reset during inhibit");

    // Device never clocks: watchdog fires 2000 cycles after entering SEND
    d0 = done_cnt;
    e0 = error_cnt;
    start_frame(8'h5A);
    w = 0;
    while (w < 3000) begin
      @(negedge clk);
      w++;
      if (tx_if.error) break;
    end
    check("timeout_cycles", 32'(w), 32'd2000);
    check("timeout_release", {29'd0, ps2_clk_oe, ps2_data_oe, tx_if.busy}, 32'b000);
    check("timeout_pulses", {(done_cnt - d0), (error_cnt - e0)} , {32'd0, 32'd1});
    repeat (10) @(negedge clk);
    $display("frame data=5a no device clock, waited=%0d", w);

    check("pulse_width_exclusive", 32'(pulse_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
